// File: rtl/inst_dispatcher.sv
// Instruction dispatcher: routes the payload of each queue entry to core 0, core 1 or both, and handles barriers.
// Optional performance counters are enabled by defining DISPATCH_PERF_CNT_EN.
module inst_dispatcher #(
  parameter int INST_WIDTH      = 512,
  parameter int CORE_INST_WIDTH = 256,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INST_WIDTH-1:0]      in_inst,
  output logic                       core0_valid,
  output logic                       core1_valid,
  input  logic                       core0_ready,
  input  logic                       core1_ready,
  output logic [CORE_INST_WIDTH-1:0] core0_inst,
  output logic [CORE_INST_WIDTH-1:0] core1_inst,
  input  logic                       core0_idle,
  input  logic                       core1_idle,
  input  logic                       flush,
  output logic                       disp_busy,
  output logic [1:0]                 dbg_state
`ifdef DISPATCH_PERF_CNT_EN
  ,
  input  logic                       perf_clr,
  output logic [CNT_WIDTH-1:0]       perf_core0_cnt,
  output logic [CNT_WIDTH-1:0]       perf_core1_cnt,
  output logic [CNT_WIDTH-1:0]       perf_stall_cnt
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; a valid
  // payload holds its data until taken; in_ready never depends on in_valid.
  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_SYNC  = 2'd2
  } state_t;

  state_t state;

  logic [1:0]                 dest;
  logic [CORE_INST_WIDTH-1:0] payload;
  logic                       accept;
  logic                       load0;
  logic                       load1;
  logic                       free0;
  logic                       free1;
  logic                       unused_inst_bits;

  assign dest             = in_inst[INST_WIDTH-1 -: 2];
  assign payload          = in_inst[CORE_INST_WIDTH-1:0];
  assign unused_inst_bits = ^in_inst[INST_WIDTH-3:CORE_INST_WIDTH];

  assign free0 = !core0_valid || core0_ready;
  assign free1 = !core1_valid || core1_ready;

  // A broadcast needs both slots free; a barrier is always taken while running.
  always_comb begin
    in_ready = 1'b0;
    if (resetn && !flush && state == S_RUN) begin
      if (dest == 2'b00) begin
        in_ready = 1'b1;
      end else begin
        in_ready = (!dest[0] || free0) && (!dest[1] || free1);
      end
    end
  end

  assign accept    = in_valid && in_ready;
  assign load0     = accept && dest[0];
  assign load1     = accept && dest[1];
  assign disp_busy = core0_valid || core1_valid || (state != S_RUN);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_RUN;
    end else if (flush) begin
      state <= S_RUN;
    end else begin
      case (state)
        S_RUN:   if (accept && dest == 2'b00) state <= S_DRAIN;
        S_DRAIN: if (!core0_valid && !core1_valid) state <= S_SYNC;
        S_SYNC:  if (core0_idle && core1_idle) state <= S_RUN;
        default: state <= S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      core0_valid <= 1'b0;
      core0_inst  <= '0;
    end else if (flush) begin
      core0_valid <= 1'b0;
    end else if (load0) begin
      core0_valid <= 1'b1;
      core0_inst  <= payload;
    end else if (core0_valid && core0_ready) begin
      core0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      core1_valid <= 1'b0;
      core1_inst  <= '0;
    end else if (flush) begin
      core1_valid <= 1'b0;
    end else if (load1) begin
      core1_valid <= 1'b1;
      core1_inst  <= payload;
    end else if (core1_valid && core1_ready) begin
      core1_valid <= 1'b0;
    end
  end

`ifdef DISPATCH_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Counters survive flush; only reset and perf_clr zero them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_core0_cnt <= '0;
      perf_core1_cnt <= '0;
      perf_stall_cnt <= '0;
    end else if (perf_clr) begin
      perf_core0_cnt <= '0;
      perf_core1_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (core0_valid && core0_ready && perf_core0_cnt != CNT_MAX)
        perf_core0_cnt <= perf_core0_cnt + CNT_ONE;
      if (core1_valid && core1_ready && perf_core1_cnt != CNT_MAX)
        perf_core1_cnt <= perf_core1_cnt + CNT_ONE;
      if (in_valid && !in_ready && perf_stall_cnt != CNT_MAX)
        perf_stall_cnt <= perf_stall_cnt + CNT_ONE;
    end
  end
`else
  localparam int unused_cnt_width = CNT_WIDTH;
`endif

endmodule

// File: tb/tb_inst_dispatcher.sv
// Bench for inst_dispatcher: directed scenarios, a cycle-level reference model with a per-cycle compare
// process, and literal spot checks. Counter checks are active when DISPATCH_PERF_CNT_EN is defined.
module tb_inst_dispatcher;
  localparam int IW = 512;
  localparam int CW = 256;
  localparam int NW = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_inst;
  logic          core0_valid, core1_valid;
  logic          core0_ready, core1_ready;
  logic [CW-1:0] core0_inst, core1_inst;
  logic          core0_idle, core1_idle;
  logic          flush;
  logic          disp_busy;
  logic [1:0]    dbg_state;
`ifdef DISPATCH_PERF_CNT_EN
  logic          perf_clr;
  logic [NW-1:0] perf_core0_cnt, perf_core1_cnt, perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  inst_dispatcher #(.INST_WIDTH(IW), .CORE_INST_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .core0_valid(core0_valid), .core1_valid(core1_valid),
    .core0_ready(core0_ready), .core1_ready(core1_ready),
    .core0_inst(core0_inst), .core1_inst(core1_inst),
    .core0_idle(core0_idle), .core1_idle(core1_idle),
    .flush(flush), .disp_busy(disp_busy), .dbg_state(dbg_state)
`ifdef DISPATCH_PERF_CNT_EN
    , .perf_clr(perf_clr), .perf_core0_cnt(perf_core0_cnt),
    .perf_core1_cnt(perf_core1_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: slot contents, barrier phase, counters
  logic          m_v[2];
  logic [CW-1:0] m_inst[2];
  int            m_phase = 0;  // 0 running, 1 waiting for slots empty, 2 waiting for idle
  longint        m_cnt[3];
  longint        sat_max = (64'd1 << NW) - 1;

  initial begin
    m_v[0] = 0; m_v[1] = 0; m_inst[0] = '0; m_inst[1] = '0;
    m_cnt[0] = 0; m_cnt[1] = 0; m_cnt[2] = 0;
  end

  function automatic logic exp_ready();
    logic [1:0] d;
    d = in_inst[IW-1 -: 2];
    if (!resetn || flush || m_phase != 0) return 1'b0;
    if (d == 2'b00) return 1'b1;
    if (d[0] && m_v[0] && !core0_ready) return 1'b0;
    if (d[1] && m_v[1] && !core1_ready) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_v[0] = 0; m_v[1] = 0; m_inst[0] = '0; m_inst[1] = '0; m_phase = 0;
      m_cnt[0] = 0; m_cnt[1] = 0; m_cnt[2] = 0;
    end else begin
      logic acc, h0, h1, st;
      logic [1:0] d;
      d   = in_inst[IW-1 -: 2];
      acc = in_valid && exp_ready();
      st  = in_valid && !exp_ready();
      h0  = m_v[0] && core0_ready;
      h1  = m_v[1] && core1_ready;
`ifdef DISPATCH_PERF_CNT_EN
      if (perf_clr) begin
        m_cnt[0] = 0; m_cnt[1] = 0; m_cnt[2] = 0;
      end else begin
        if (h0 && m_cnt[0] < sat_max) m_cnt[0]++;
        if (h1 && m_cnt[1] < sat_max) m_cnt[1]++;
        if (st && m_cnt[2] < sat_max) m_cnt[2]++;
      end
`endif
      if (flush) begin
        m_v[0] = 0; m_v[1] = 0; m_phase = 0;
      end else begin
        if (m_phase == 0 && acc && d == 2'b00) m_phase = 1;
        else if (m_phase == 1 && !m_v[0] && !m_v[1]) m_phase = 2;
        else if (m_phase == 2 && core0_idle && core1_idle) m_phase = 0;
        for (int i = 0; i < 2; i++) begin
          if (acc && d[i]) begin
            m_v[i] = 1; m_inst[i] = in_inst[CW-1:0];
          end else if (i == 0 ? h0 : h1) begin
            m_v[i] = 0;
          end
        end
      end
    end
  end

  // scoreboard compare: every cycle, away from the active edge
  always @(negedge clk) begin
    chk("in_ready", in_ready, exp_ready());
    chk("core0_valid", core0_valid, m_v[0]);
    chk("core1_valid", core1_valid, m_v[1]);
    chk("core0_inst", core0_inst, m_inst[0]);
    chk("core1_inst", core1_inst, m_inst[1]);
    chk("disp_busy", disp_busy, m_v[0] || m_v[1] || m_phase != 0);
`ifdef DISPATCH_PERF_CNT_EN
    chk("perf_core0_cnt", perf_core0_cnt, m_cnt[0][NW-1:0]);
    chk("perf_core1_cnt", perf_core1_cnt, m_cnt[1][NW-1:0]);
    chk("perf_stall_cnt", perf_stall_cnt, m_cnt[2][NW-1:0]);
`endif
  end

  int hs1_cnt = 0;
  always @(negedge clk) if (core1_valid && core1_ready) hs1_cnt++;

  // driver tasks
  function automatic logic [IW-1:0] mk(input logic [1:0] d, input logic [CW-1:0] p);
    logic [IW-1:0] w;
    w = '0;
    w[IW-1 -: 2] = d;
    w[383:256]   = {4{32'hdeadbeef}};
    w[CW-1:0]    = p;
    return w;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] d, input logic [CW-1:0] p, output int waited);
    logic acc;
    in_valid = 1'b1;
    in_inst  = mk(d, p);
    waited   = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      waited++;
      if (waited > 40) begin
        chk("send_timeout", 1'b1, 1'b0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_clr();
`ifdef DISPATCH_PERF_CNT_EN
    perf_clr = 1'b1;
    tick(1);
    perf_clr = 1'b0;
`endif
  endtask

  int w;
  int wsum;

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_inst = '0; flush = 1'b0;
    core0_ready = 1'b1; core1_ready = 1'b1; core0_idle = 1'b1; core1_idle = 1'b1;
`ifdef DISPATCH_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
    tick(3);
    chk("reset_in_ready", in_ready, 1'b0);
    chk("reset_busy", disp_busy, 1'b0);
    chk("reset_core0_inst", core0_inst, '0);
    resetn = 1'b1;
    tick(1);

    // single core-0 instruction
    send(2'b01, 256'hA5, w);
    chk("s1_wait", w, 0);
    chk("s1_v0", core0_valid, 1'b1);
    chk("s1_inst0", core0_inst, 256'hA5);
    chk("s1_v1", core1_valid, 1'b0);
    tick(2);

    // broadcast with core 1 stalled for 3 cycles
    core1_ready = 1'b0;
    send(2'b11, 256'h11, w);
    chk("s2_v0_c1", core0_valid, 1'b1);
    chk("s2_v1_c1", core1_valid, 1'b1);
    tick(1);
    chk("s2_v0_c2", core0_valid, 1'b0);
    chk("s2_v1_c2", core1_valid, 1'b1);
    chk("s2_inst1_c2", core1_inst, 256'h11);
    tick(2);
    core1_ready = 1'b1;
    send(2'b11, 256'h22, w);
    chk("s2_next_wait", w, 0);
    chk("s2_inst0_next", core0_inst, 256'h22);
    chk("s2_inst1_next", core1_inst, 256'h22);
    tick(2);

    // 8 back-to-back core-1 instructions
    pulse_clr();
    hs1_cnt = 0;
    wsum = 0;
    for (int i = 0; i < 8; i++) begin
      send(2'b10, 256'(32'h100 + i), w);
      wsum += w;
    end
    tick(2);
    chk("s3_wait_sum", wsum, 0);
    chk("s3_hs1", hs1_cnt, 8);
`ifdef DISPATCH_PERF_CNT_EN
    chk("s3_perf1", perf_core1_cnt, 32'd8);
`endif

    // minimum-cost barrier
    send(2'b00, 256'hB0, w);
    send(2'b10, 256'h44, w);
    chk("s4_min_wait", w, 2);
    tick(2);

    // barrier with core 0 busy for 5 cycles after the slots empty
    core0_idle = 1'b0;
    send(2'b00, 256'hB1, w);
    in_valid = 1'b1;
    in_inst  = mk(2'b01, 256'h33);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) core0_idle = 1'b1;
      @(negedge clk);
      chk("s4_hold_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    send(2'b01, 256'h33, w);
    chk("s4_after_idle_wait", w, 0);
    tick(2);

    // flush with both slots full and cores stalled
    core0_ready = 1'b0; core1_ready = 1'b0;
    send(2'b11, 256'h55, w);
    in_valid = 1'b1;
    in_inst  = mk(2'b01, 256'h56);
    flush    = 1'b1;
    @(negedge clk);
    chk("s5_flush_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("s5_v0", core0_valid, 1'b0);
    chk("s5_v1", core1_valid, 1'b0);
    chk("s5_busy", disp_busy, 1'b0);

    // flush out of a barrier wait
    send(2'b11, 256'h66, w);
    send(2'b00, 256'hB2, w);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("s5b_busy", disp_busy, 1'b0);
    in_inst = mk(2'b01, 256'h67);
    @(negedge clk);
    chk("s5b_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // stall counting on a full, stalled core-0 slot
    pulse_clr();
    send(2'b01, 256'h77, w);
    in_valid = 1'b1;
    in_inst  = mk(2'b01, 256'h88);
    tick(10);
    in_valid = 1'b0;
    tick(1);
    chk("s6_inst0_stable", core0_inst, 256'h77);
`ifdef DISPATCH_PERF_CNT_EN
    chk("s6_stall", perf_stall_cnt, 32'd10);
    pulse_clr();
    chk("s6_clr", perf_stall_cnt, 32'd0);
`endif
    core0_ready = 1'b1; core1_ready = 1'b1;
    tick(2);

    // asynchronous reset in mid-operation
    core0_ready = 1'b0; core1_ready = 1'b0;
    send(2'b11, 256'h99, w);
    #2;
    resetn = 1'b0;
    #1;
    chk("s7_v0", core0_valid, 1'b0);
    chk("s7_v1", core1_valid, 1'b0);
    chk("s7_inst1", core1_inst, '0);
    tick(2);
    resetn = 1'b1;
    core0_ready = 1'b1; core1_ready = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_dispatcher.md
# inst_dispatcher

Instruction dispatcher between `instructionQueue` and two `core` instances. It accepts the 512-bit instruction stream and decodes a 2-bit destination field. Each instruction's 256-bit payload goes to core 0, core 1 or both. Barrier instructions hold issue until both cores have drained and gone idle. One registered output slot per core gives one-cycle latency and full throughput.

## Interface
- `INST_WIDTH`, 512, width of the incoming instruction word.
- `CORE_INST_WIDTH`, 256, payload width forwarded to each core.
- `CNT_WIDTH`, 32, width of each performance counter (macro-enabled only).

- `clk`  in  1  single clock for the whole block.
- `resetn`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  instruction valid from the queue.
- `in_ready`  out  1  instruction accepted when `in_valid && in_ready`.
- `in_inst`  in  INST_WIDTH  instruction. Bits [INST_WIDTH-1:INST_WIDTH-2] are `dest`; bits [CORE_INST_WIDTH-1:0] are the payload.
- `core0_valid`, `core1_valid`  out  1  payload valid toward core N.
- `core0_ready`, `core1_ready`  in  1  core N accepts the payload.
- `core0_inst`, `core1_inst`  out  CORE_INST_WIDTH  payload toward core N.
- `core0_idle`, `core1_idle`  in  1  core N has no work in flight. A core must drop this within 1 cycle of accepting a payload.
- `flush`  in  1  synchronous abort of pending dispatch.
- `disp_busy`  out  1  high when any slot is full or the FSM is not in S_RUN.

## Operation
- `dest` encoding:
  - 2'b01: core 0.
  - 2'b10: core 1.
  - 2'b11: broadcast to both cores.
  - 2'b00: barrier, consumed and never forwarded.
- Slot N is full when `coreN_valid` is 1. It drains on `coreN_valid && coreN_ready`.
- FSM states: S_RUN, S_DRAIN, S_SYNC.
- S_RUN, non-barrier: `in_ready` = AND, over each targeted core N, of `!coreN_valid || coreN_ready`.
  - On accept, each targeted slot loads the payload and sets valid.
  - Untargeted slots are unaffected.
- Broadcast is atomic on the input side: accepted only when both slots can take it.
  - The two outputs may drain on different cycles.
- S_RUN, barrier: `in_ready`=1 and the barrier is accepted; go to S_DRAIN.
- S_DRAIN: `in_ready`=0. When both slots are empty, go to S_SYNC.
- S_SYNC: `in_ready`=0. When `core0_idle && core1_idle`, go to S_RUN.
- `flush` has the highest priority:
  - both valids clear; FSM goes to S_RUN;
  - `in_ready`=0 in the flush cycle;
  - counters are kept.
- Simultaneous drain and load of the same slot in one cycle: the new payload is loaded and valid stays 1.

## Timing
- Reset values: `in_ready`=0, `core0_valid`=`core1_valid`=0, `core0_inst`=`core1_inst`=0, `disp_busy`=0, FSM in S_RUN, all counters 0.
  - `in_ready` is combinational, so it may go high in the first cycle after reset deassertion.
- Latency: accept at edge N gives `coreN_valid`=1 from cycle N+1.
- Throughput: 1 instruction/cycle while the targeted cores hold ready high.
- Stability: `coreN_inst` is stable while `coreN_valid && !coreN_ready`.
- `in_ready` depends combinationally on `dest`, `coreN_ready` and the FSM state, not on `in_valid`.
- Barrier minimum cost: accept, then 1 cycle in S_DRAIN (slots already empty), then 1 cycle in S_SYNC. The next instruction is accepted 3 cycles after the barrier.
- Reset asserted mid-operation: all state clears immediately and asynchronously; any in-flight payloads are dropped.

## Configuration
- `DISPATCH_PERF_CNT_EN` defined:
  - Adds input `perf_clr` (1 bit) and outputs `perf_core0_cnt`, `perf_core1_cnt`, `perf_stall_cnt` (CNT_WIDTH each).
  - `perf_core0_cnt` / `perf_core1_cnt` count core 0 / core 1 handshakes.
  - `perf_stall_cnt` counts cycles with `in_valid && !in_ready`.
  - All counters saturate at 2^CNT_WIDTH-1.
  - `perf_clr` clears all counters synchronously and has priority over the increment in the same cycle.
- Not defined: these ports and registers do not exist. Dispatch behaviour is identical.

## Test plan
- Dest 01, payload 0xA5, `core0_ready`=1 -> `core0_valid` high 1 cycle after accept with `core0_inst`=0xA5; `core1_valid` stays 0.
- Broadcast 0x11 with `core1_ready`=0 for 3 cycles -> core 0 drains at cycle 1, `core1_valid` is held with 0x11 until cycle 4, then a next broadcast is accepted in that same cycle.
- 8 back-to-back dest 10 instructions, `core1_ready`=1 -> 8 handshakes on 8 consecutive cycles; `perf_core1_cnt`=8.
- Barrier with `core0_idle` held low for 5 cycles after the slots empty -> `in_ready`=0 throughout; following instruction accepted 1 cycle after `core0_idle` rises.
- `flush` while both slots are full and ready=0 -> both valids 0 next cycle, FSM in S_RUN, `in_ready`=0 in the flush cycle.
- `in_valid`=1 with `core0_ready`=0 for 10 cycles on dest 01 with slot full -> `perf_stall_cnt`=10; `perf_clr` pulse -> 0.
